rom_stream_tx: RTL and testbench
================================

ROM_STREAM_TX -- requirements
Module: rom_stream_tx

Interface
REQ-001 SHALL have parameter WR_GAP, default 2: idle cycles between consecutive ioctl_wr pulses (0..15).
REQ-002 SHALL have port CLK  input  1  single clock for all logic.
REQ-003 SHALL have port RESETn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a transfer, sampled only in IDLE.
REQ-005 SHALL have port abort  input  1  terminates any transfer in progress.
REQ-006 SHALL have port src_base  input  25  first source memory address.
REQ-007 SHALL have port dst_base  input  25  first ioctl_addr emitted.
REQ-008 SHALL have port length  input  25  byte count to transfer.
REQ-009 SHALL have port src_addr  output  25  source read address.
REQ-010 SHALL have port src_rd  output  1  one-cycle source read strobe.
REQ-011 SHALL have port src_data  input  8  source read data, valid when src_ack=1.
REQ-012 SHALL have port src_ack  input  1  source data-valid strobe, variable latency.
REQ-013 SHALL have port ioctl_download  output  1  high for the whole transfer.
REQ-014 SHALL have port ioctl_addr  output  25  destination byte address.
REQ-015 SHALL have port ioctl_dout  output  8  destination byte.
REQ-016 SHALL have port ioctl_wr  output  1  one-cycle write strobe.
REQ-017 SHALL have ports busy (output 1, high when not IDLE) and done (output 1, one-cycle completion pulse).

Function
REQ-018 SHALL implement states IDLE, REQ, WAIT, WRITE, GAP, FINISH.
REQ-019 IDLE: start=1 with length!=0 SHALL latch src_base, dst_base, length, clear byte counter n, go REQ; start with length=0 SHALL go FINISH without asserting ioctl_download.
REQ-020 start while not IDLE SHALL be ignored; latched values SHALL NOT change mid-transfer.
REQ-021 ioctl_download SHALL be registered high from the first cycle in REQ until the FINISH cycle, where it is low.
REQ-022 REQ: src_rd=1 for exactly one cycle with src_addr=src_base+n (mod 2^25); next state WAIT.
REQ-023 WAIT: hold until src_ack=1; in that cycle capture src_data into ioctl_dout and set ioctl_addr=dst_base+n (mod 2^25); next state WRITE.
REQ-024 src_ack in the same cycle as src_rd, or in any state other than WAIT, SHALL be ignored.
REQ-025 WRITE: ioctl_wr=1 for exactly one cycle; ioctl_addr/ioctl_dout SHALL be stable from the cycle before ioctl_wr through the next WAIT capture; n increments.
REQ-026 After WRITE: if n+1==length go FINISH; else if WR_GAP=0 go REQ; else go GAP.
REQ-027 GAP: remain exactly WR_GAP cycles, then REQ; consecutive ioctl_wr pulses SHALL be separated by at least WR_GAP+2 cycles (REQ, WAIT minimum).
REQ-028 FINISH: done=1 for one cycle, busy=0 next cycle, return to IDLE.
REQ-029 n and all address arithmetic SHALL be 25-bit, wrapping modulo 2^25 without error.
REQ-030 abort=1 in any non-IDLE state SHALL force IDLE next cycle: ioctl_download=0, ioctl_wr=0, src_rd=0, done not pulsed; abort in IDLE has no effect; abort wins over simultaneous src_ack or start.
REQ-031 No extra ioctl_wr SHALL be produced after the last byte, after abort, or in IDLE.

Reset
REQ-032 RESETn=0 SHALL asynchronously force IDLE, n=0, ioctl_download=0, ioctl_wr=0, ioctl_addr=0, ioctl_dout=0, src_rd=0, src_addr=0, busy=0, done=0.
REQ-033 Reset mid-transfer SHALL discard the transfer with no done pulse; first start after RESETn release SHALL behave as from power-up.

Verification
REQ-034 src_base=0x100, dst_base=0x20000, length=4, WR_GAP=2, src_ack 1 cycle after src_rd, memory[0x100..0x103]=A1,B2,C3,D4 -> ioctl_wr at addr 0x20000..0x20003 with A1,B2,C3,D4, 5-cycle pulse spacing, done once, ioctl_download low on done cycle.
REQ-035 length=0 start -> done pulse, no src_rd, no ioctl_wr, ioctl_download never high.
REQ-036 src_ack delayed 7 cycles on byte 2, plus spurious src_ack in GAP -> data unchanged, no extra ioctl_wr, exactly length strobes.
REQ-037 dst_base=0x1FFFFFF, length=2 -> ioctl_addr 0x1FFFFFF then 0x0000000.
REQ-038 abort asserted in WAIT of byte 3 of 8 -> next cycle IDLE, 2 writes total, no done; new start then completes all 8.
REQ-039 RESETn pulsed low during GAP -> outputs zero immediately (asynchronous), no done; start while busy during a separate run -> ignored.

Source files
------------

// File: rtl/rom_stream_tx_if.sv
// rom_stream_tx_if -- bus bundle between rom_stream_tx and its neighbours.
//   Source side : src_addr/src_rd out, src_data/src_ack back (variable latency).
//   Sink side   : ioctl_download/ioctl_addr/ioctl_dout/ioctl_wr out.
// master = the transmitter, slave = source memory plus ioctl sink.
interface rom_stream_tx_if;
  logic [24:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data;
  logic        src_ack;
  logic        ioctl_download;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;

  modport master (
    output src_addr, src_rd, ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
    input  src_data, src_ack
  );

  modport slave (
    input  src_addr, src_rd, ioctl_download, ioctl_addr, ioctl_dout, ioctl_wr,
    output src_data, src_ack
  );
endinterface

// File: rtl/rom_stream_tx.sv
// rom_stream_tx -- copies `length` bytes from a variable-latency source memory
// to an ioctl-style byte download port, one byte at a time.
//   CLK, RESETn     : clock, asynchronous active-low reset
//   start           : one-cycle request, only looked at while idle
//   abort           : drops any transfer in progress back to idle
//   src_base        : first source address
//   dst_base        : first ioctl_addr emitted
//   length          : byte count (0 = immediate done, no download)
//   busy / done     : not idle / one-cycle completion pulse
//   bus (master)    : src_addr/src_rd/src_data/src_ack and ioctl_* signals
// WR_GAP sets the idle cycles inserted after every ioctl_wr (0..15).
module rom_stream_tx #(
  parameter int WR_GAP = 2
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        start,
  input  logic        abort,
  input  logic [24:0] src_base,
  input  logic [24:0] dst_base,
  input  logic [24:0] length,
  output logic        busy,
  output logic        done,
  rom_stream_tx_if.master bus
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_REQ    = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_WRITE  = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  // Last count value of the gap timer; unused when WR_GAP is 0.
  localparam logic [3:0] GAP_LAST = 4'(WR_GAP - 1);

  logic [2:0]  state;
  logic [24:0] src_q;
  logic [24:0] dst_q;
  logic [24:0] len_q;
  logic [24:0] n;
  logic [24:0] n_inc;
  logic [3:0]  gap_cnt;

  assign n_inc = n + 25'd1;

  // Strobes decode straight from state so reset clears them without a clock.
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);
  assign bus.src_rd = (state == S_REQ);
  assign bus.ioctl_wr = (state == S_WRITE);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state              <= S_IDLE;
      src_q              <= '0;
      dst_q              <= '0;
      len_q              <= '0;
      n                  <= '0;
      gap_cnt            <= '0;
      bus.src_addr       <= '0;
      bus.ioctl_addr     <= '0;
      bus.ioctl_dout     <= '0;
      bus.ioctl_download <= 1'b0;
    end else if (abort && state != S_IDLE) begin
      // Abort beats any ack or start seen in the same cycle.
      state              <= S_IDLE;
      bus.ioctl_download <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            if (length != '0) begin
              src_q              <= src_base;
              dst_q              <= dst_base;
              len_q              <= length;
              n                  <= '0;
              bus.src_addr       <= src_base;
              bus.ioctl_download <= 1'b1;
              state              <= S_REQ;
            end else begin
              state <= S_FINISH;
            end
          end
        end
        S_REQ: state <= S_WAIT;
        S_WAIT: begin
          if (bus.src_ack) begin
            bus.ioctl_dout <= bus.src_data;
            bus.ioctl_addr <= dst_q + n;
            state          <= S_WRITE;
          end
        end
        S_WRITE: begin
          n <= n_inc;
          if (n_inc == len_q) begin
            bus.ioctl_download <= 1'b0;
            state              <= S_FINISH;
          end else if (WR_GAP == 0) begin
            bus.src_addr <= src_q + n_inc;
            state        <= S_REQ;
          end else begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end
        end
        S_GAP: begin
          // n already advanced in WRITE, so it points at the next byte here.
          if (gap_cnt == GAP_LAST) begin
            bus.src_addr <= src_q + n;
            state        <= S_REQ;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_stream_tx.sv
module tb_rom_stream_tx;
  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [24:0] src_base = '0;
  logic [24:0] dst_base = '0;
  logic [24:0] length = '0;
  logic        busy, done;

  rom_stream_tx_if bus();

  rom_stream_tx #(.WR_GAP(2)) dut (
    .CLK(CLK), .RESETn(RESETn), .start(start), .abort(abort),
    .src_base(src_base), .dst_base(dst_base), .length(length),
    .busy(busy), .done(done), .bus(bus)
  );

  always #5 CLK = ~CLK;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Source memory contents: fixed bytes at 0x100.., a hash elsewhere.
  function automatic logic [7:0] mem_byte(input logic [24:0] a);
    case (a)
      25'h100: return 8'hA1;
      25'h101: return 8'hB2;
      25'h102: return 8'hC3;
      25'h103: return 8'hD4;
      default: return a[7:0] ^ a[15:8] ^ {a[24:20], 3'b101};
    endcase
  endfunction

  // Responder knobs
  bit rand_dly = 0;
  bit spur_en  = 0;
  int slow_idx = -1;
  int slow_dly = 7;

  // Source memory responder: ack `dly` cycles after each src_rd.
  initial begin
    bit          pend = 0, spur_next = 0;
    int          cnt = 0, dly;
    logic [24:0] la = '0;
    bus.src_ack  = 1'b0;
    bus.src_data = 8'h00;
    forever begin
      @(negedge CLK);
      bus.src_ack = 1'b0;
      if (!busy) begin pend = 0; spur_next = 0; end
      if (spur_next) begin
        bus.src_ack = 1'b1; bus.src_data = 8'hEE; spur_next = 0;
      end
      if (pend) begin
        if (cnt == 0) begin
          bus.src_ack = 1'b1; bus.src_data = mem_byte(la); pend = 0;
        end else cnt--;
      end
      if (bus.src_rd) begin
        pend = 1; la = bus.src_addr;
        dly = rand_dly ? int'($urandom_range(1, 4)) : 1;
        if (slow_idx >= 0 && int'(25'(bus.src_addr - src_base)) == slow_idx) dly = slow_dly;
        cnt = dly - 1;
        if (spur_en) begin bus.src_ack = 1'b1; bus.src_data = 8'hEE; end
      end
      if (spur_en && bus.ioctl_wr) spur_next = 1;
    end
  end

  // Sink monitor: logs every write and counts strobes.
  logic [24:0] wr_a[$];
  logic [7:0]  wr_d[$];
  int          wr_t[$];
  int cyc = 0, rd_n = 0, done_n = 0, dl_n = 0, dl_done_bad = 0;
  initial forever begin
    @(negedge CLK);
    cyc++;
    if (bus.ioctl_wr) begin
      wr_a.push_back(bus.ioctl_addr); wr_d.push_back(bus.ioctl_dout); wr_t.push_back(cyc);
    end
    if (bus.src_rd) rd_n++;
    if (bus.ioctl_download) dl_n++;
    if (done) begin done_n++; if (bus.ioctl_download) dl_done_bad++; end
  end

  task automatic start_xfer(input logic [24:0] s, input logic [24:0] d, input logic [24:0] l);
    @(negedge CLK);
    src_base = s; dst_base = d; length = l; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit, output bit to);
    to = 1;
    for (int i = 0; i < limit; i++) begin
      if (done) begin to = 0; break; end
      @(negedge CLK);
    end
    repeat (4) @(negedge CLK);
    #1;
  endtask

  task automatic test_reset();
    #1;
    chk_cnt++;
    if ({busy, done, bus.ioctl_wr, bus.ioctl_download, bus.src_rd} !== 5'b0) $display("FAIL reset_strobes got %b want 00000", {busy, done, bus.ioctl_wr, bus.ioctl_download, bus.src_rd});
    else pass_cnt++;
    chk_cnt++;
    if ({bus.src_addr, bus.ioctl_addr, bus.ioctl_dout} !== 58'b0) $display("FAIL reset_buses got %h/%h/%h want 0", bus.src_addr, bus.ioctl_addr, bus.ioctl_dout);
    else pass_cnt++;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    chk_cnt++;
    if (busy !== 1'b0) $display("FAIL idle_after_reset busy=%b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_basic();
    int w0 = wr_a.size(), d0 = done_n, r0 = rd_n, b0 = dl_done_bad;
    bit to;
    start_xfer(25'h100, 25'h20000, 25'd4);
    wait_done(200, to);
    chk_cnt++; if (to) $display("FAIL basic_timeout no done"); else pass_cnt++;
    chk_cnt++;
    if (wr_a.size() - w0 !== 4) $display("FAIL basic_wr_count got %0d want 4", wr_a.size() - w0); else pass_cnt++;
    for (int i = 0; i < 4 && w0 + i < wr_a.size(); i++) begin
      chk_cnt++;
      if ({wr_a[w0+i], wr_d[w0+i]} !== {25'(25'h20000 + i), mem_byte(25'(25'h100 + i))})
        $display("FAIL basic_wr%0d got %h:%h want %h:%h", i, wr_a[w0+i], wr_d[w0+i], 25'(25'h20000 + i), mem_byte(25'(25'h100 + i)));
      else pass_cnt++;
      if (i > 0) begin
        chk_cnt++;
        if (wr_t[w0+i] - wr_t[w0+i-1] !== 5) $display("FAIL basic_spacing%0d got %0d want 5", i, wr_t[w0+i] - wr_t[w0+i-1]);
        else pass_cnt++;
      end
    end
    chk_cnt++; if (done_n - d0 !== 1) $display("FAIL basic_done got %0d want 1", done_n - d0); else pass_cnt++;
    chk_cnt++; if (rd_n - r0 !== 4) $display("FAIL basic_src_rd got %0d want 4", rd_n - r0); else pass_cnt++;
    chk_cnt++; if (dl_done_bad !== b0) $display("FAIL basic_dl_on_done got %0d want %0d", dl_done_bad, b0); else pass_cnt++;
    chk_cnt++; if (busy !== 1'b0) $display("FAIL basic_busy got %b want 0", busy); else pass_cnt++;
  endtask

  task automatic test_zero_len();
    int w0 = wr_a.size(), d0 = done_n, r0 = rd_n, l0 = dl_n;
    bit to;
    start_xfer(25'h100, 25'h20000, 25'd0);
    wait_done(20, to);
    chk_cnt++; if (to) $display("FAIL zero_timeout no done"); else pass_cnt++;
    chk_cnt++;
    if ({done_n - d0, rd_n - r0, wr_a.size() - w0, dl_n - l0} !== {32'd1, 32'd0, 32'd0, 32'd0})
      $display("FAIL zero_len done=%0d rd=%0d wr=%0d dl=%0d want 1 0 0 0", done_n - d0, rd_n - r0, wr_a.size() - w0, dl_n - l0);
    else pass_cnt++;
  endtask

  task automatic test_slow_ack();
    int w0 = wr_a.size();
    logic [24:0] s = 25'($urandom), d = 25'($urandom);
    bit to;
    slow_idx = 1; slow_dly = 7; spur_en = 1;
    start_xfer(s, d, 25'd5);
    wait_done(300, to);
    repeat (5) @(negedge CLK);
    #1;
    slow_idx = -1; spur_en = 0;
    chk_cnt++; if (to) $display("FAIL slow_timeout no done"); else pass_cnt++;
    chk_cnt++;
    if (wr_a.size() - w0 !== 5) $display("FAIL slow_wr_count got %0d want 5", wr_a.size() - w0); else pass_cnt++;
    for (int i = 0; i < 5 && w0 + i < wr_a.size(); i++) begin
      chk_cnt++;
      if ({wr_a[w0+i], wr_d[w0+i]} !== {25'(d + i), mem_byte(25'(s + i))})
        $display("FAIL slow_wr%0d got %h:%h want %h:%h", i, wr_a[w0+i], wr_d[w0+i], 25'(d + i), mem_byte(25'(s + i)));
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    int w0 = wr_a.size();
    bit to;
    start_xfer(25'h1FFFFFF, 25'h1FFFFFF, 25'd2);
    wait_done(100, to);
    chk_cnt++; if (to) $display("FAIL wrap_timeout no done"); else pass_cnt++;
    chk_cnt++;
    if (wr_a.size() - w0 !== 2) $display("FAIL wrap_wr_count got %0d want 2", wr_a.size() - w0);
    else if ({wr_a[w0], wr_a[w0+1], wr_d[w0+1]} !== {25'h1FFFFFF, 25'h0, mem_byte(25'h0)})
      $display("FAIL wrap_addr got %h,%h data %h want 1ffffff,0000000 data %h", wr_a[w0], wr_a[w0+1], wr_d[w0+1], mem_byte(25'h0));
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int w0 = wr_a.size(), d0 = done_n, k, w1, d1;
    logic [24:0] s = 25'($urandom), d = 25'($urandom);
    bit to;
    start_xfer(s, d, 25'd8);
    k = bus.src_rd ? 1 : 0;
    for (int i = 0; i < 200 && k < 3; i++) begin
      @(negedge CLK);
      if (bus.src_rd) k++;
    end
    @(negedge CLK);   // WAIT of byte 3; the ack lands here too
    abort = 1'b1; start = 1'b1;
    @(negedge CLK);
    abort = 1'b0; start = 1'b0;
    #1;
    chk_cnt++;
    if ({busy, bus.ioctl_download, bus.ioctl_wr, bus.src_rd} !== 4'b0)
      $display("FAIL abort_idle busy/dl/wr/rd got %b want 0000", {busy, bus.ioctl_download, bus.ioctl_wr, bus.src_rd});
    else pass_cnt++;
    repeat (10) @(negedge CLK);
    #1;
    chk_cnt++;
    if ({wr_a.size() - w0, done_n - d0} !== {32'd2, 32'd0})
      $display("FAIL abort_counts wr=%0d done=%0d want 2 0", wr_a.size() - w0, done_n - d0);
    else pass_cnt++;
    w1 = wr_a.size(); d1 = done_n;
    start_xfer(s, d, 25'd8);
    wait_done(400, to);
    chk_cnt++; if (to) $display("FAIL abort_rerun_timeout no done"); else pass_cnt++;
    chk_cnt++;
    if ({wr_a.size() - w1, done_n - d1} !== {32'd8, 32'd1})
      $display("FAIL abort_rerun wr=%0d done=%0d want 8 1", wr_a.size() - w1, done_n - d1);
    else pass_cnt++;
    for (int i = 0; i < 8 && w1 + i < wr_a.size(); i++) begin
      chk_cnt++;
      if ({wr_a[w1+i], wr_d[w1+i]} !== {25'(d + i), mem_byte(25'(s + i))})
        $display("FAIL abort_rerun_wr%0d got %h:%h want %h:%h", i, wr_a[w1+i], wr_d[w1+i], 25'(d + i), mem_byte(25'(s + i)));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int w0 = wr_a.size(), d0 = done_n, i;
    start_xfer(25'h300, 25'h4000, 25'd6);
    for (i = 0; i < 100 && !bus.ioctl_wr; i++) @(negedge CLK);
    chk_cnt++; if (i >= 100) $display("FAIL rst_mid_timeout no write"); else pass_cnt++;
    @(negedge CLK);   // first GAP cycle
    #2 RESETn = 1'b0;
    #1;
    chk_cnt++;
    if ({busy, done, bus.ioctl_download, bus.ioctl_wr, bus.src_rd, bus.src_addr, bus.ioctl_addr, bus.ioctl_dout} !== 63'b0)
      $display("FAIL rst_mid_outputs busy=%b dl=%b src_addr=%h addr=%h dout=%h want all 0", busy, bus.ioctl_download, bus.src_addr, bus.ioctl_addr, bus.ioctl_dout);
    else pass_cnt++;
    repeat (2) @(negedge CLK);
    RESETn = 1'b1;
    repeat (5) @(negedge CLK);
    #1;
    chk_cnt++;
    if ({wr_a.size() - w0, done_n - d0} !== {32'd1, 32'd0})
      $display("FAIL rst_mid_counts wr=%0d done=%0d want 1 0", wr_a.size() - w0, done_n - d0);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored();
    int w0 = wr_a.size(), d0 = done_n;
    logic [24:0] s = 25'($urandom), d = 25'($urandom);
    bit to;
    start_xfer(s, d, 25'd5);
    repeat (3) @(negedge CLK);
    src_base = ~s; dst_base = ~d; length = 25'd2; start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    wait_done(300, to);
    chk_cnt++; if (to) $display("FAIL ign_timeout no done"); else pass_cnt++;
    chk_cnt++;
    if ({wr_a.size() - w0, done_n - d0} !== {32'd5, 32'd1})
      $display("FAIL ign_counts wr=%0d done=%0d want 5 1", wr_a.size() - w0, done_n - d0);
    else pass_cnt++;
    for (int i = 0; i < 5 && w0 + i < wr_a.size(); i++) begin
      chk_cnt++;
      if ({wr_a[w0+i], wr_d[w0+i]} !== {25'(d + i), mem_byte(25'(s + i))})
        $display("FAIL ign_wr%0d got %h:%h want %h:%h", i, wr_a[w0+i], wr_d[w0+i], 25'(d + i), mem_byte(25'(s + i)));
      else pass_cnt++;
    end
  endtask

  task automatic test_random();
    rand_dly = 1;
    for (int r = 0; r < 4; r++) begin
      int w0 = wr_a.size(), d0 = done_n, l = int'($urandom_range(1, 6));
      logic [24:0] s = 25'($urandom), d = 25'($urandom);
      bit to;
      start_xfer(s, d, 25'(l));
      wait_done(300, to);
      chk_cnt++;
      if (to || wr_a.size() - w0 !== l || done_n - d0 !== 1)
        $display("FAIL rand%0d_counts to=%0d wr=%0d done=%0d want 0 %0d 1", r, to, wr_a.size() - w0, done_n - d0, l);
      else pass_cnt++;
      for (int i = 0; i < l && w0 + i < wr_a.size(); i++) begin
        chk_cnt++;
        if ({wr_a[w0+i], wr_d[w0+i]} !== {25'(d + i), mem_byte(25'(s + i))})
          $display("FAIL rand%0d_wr%0d got %h:%h want %h:%h", r, i, wr_a[w0+i], wr_d[w0+i], 25'(d + i), mem_byte(25'(s + i)));
        else pass_cnt++;
      end
    end
    rand_dly = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_slow_ack();
    test_wrap();
    test_abort();
    test_reset_mid();
    test_start_ignored();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout bench did not finish, passed %0d of %0d", pass_cnt, chk_cnt);
    $fatal(1, "timeout");
  end
endmodule
